// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory request arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default address and data widths
//   state_e                 : sequencer states (IDLE, ISSUE, WAIT, RESP)
//   req_t                   : one requester's command {we, addr, wdata}
//   addr_in_range()         : true when an address maps onto an implemented word
package mem_ctrl_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } req_t;

  function automatic logic addr_in_range(input logic [ADDR_W_DEF-1:0] addr,
                                         input int unsigned           depth);
    return 32'(addr) < depth;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   valid      : per-requester request vector
//   last_grant : index granted most recently; search starts one above it
//   enable     : when low no grant is produced
//   grant      : one-hot grant (all zero when nothing is valid or disabled)
//   grant_idx  : encoded index of the grant (0 when there is none)
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         valid,
  input  logic [$clog2(NREQ)-1:0] last_grant,
  input  logic                    enable,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(NREQ);

  int               cand;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  // Walk the requesters in priority order last_grant+1, +2, ... wrapping,
  // and keep the first one that is valid.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand     = (int'(last_grant) + i) % NREQ;
      cand_idx = IDX_W'(cand);
      if (enable && !found && valid[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one single-port word memory between NREQ requesters. One request is
// accepted at a time (round-robin), the access is sequenced through a fixed
// read latency, and a one-cycle response goes back to the winner.
//
// Handshake: a request transfers on a rising edge where req_valid[i] and
// req_ready[i] are both high. req_ready is combinational, at most one bit is
// high, and only while idle and not in reset. Once transferred the command is
// held internally, so req_* may change freely afterwards. resp_valid is a
// single-cycle pulse with no back-pressure; resp_rdata/resp_err are only
// meaningful while it is high.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/ready/we  : per-requester handshake and direction
//   req_addr/req_wdata  : flattened per-requester address / write data
//   resp_valid/rdata/err: response pulse, read data, out-of-range flag
//   mem_en/we/addr/wdata: registered memory strobes, zero outside ISSUE
//   mem_rdata           : memory read data, valid RD_LAT cycles after mem_en
//   dbg_state           : current sequencer state (state_e encoding)
//   dbg_last_grant      : round-robin pointer
module mem_req_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int RD_LAT    = 1,
  parameter int MEM_DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          resp_valid,
  output logic [DATA_W-1:0]        resp_rdata,
  output logic                     resp_err,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [1:0]               dbg_state,
  output logic [$clog2(NREQ)-1:0]  dbg_last_grant
);

  localparam int IDX_W = $clog2(NREQ);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   id_q, id_d;
  logic               we_q, we_d;
  logic               err_q, err_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               mem_en_q, mem_en_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic [NREQ-1:0]    resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]  resp_rdata_q, resp_rdata_d;
  logic               resp_err_q, resp_err_d;

  logic [NREQ-1:0]    grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               arb_en;
  req_t               sel_req;
  logic               sel_in_range;
  logic [NREQ-1:0]    resp_onehot;

  // Reset gates the arbiter so nothing can be accepted while rst is high.
  assign arb_en = (state_q == S_IDLE) && !rst;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .valid      (req_valid),
    .last_grant (last_q),
    .enable     (arb_en),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign req_ready = grant;

  // Mux the winning requester's command out of the flattened buses.
  always_comb begin
    sel_req = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_req.we    = req_we[i];
        sel_req.addr  = ADDR_W_DEF'(req_addr[i*ADDR_W +: ADDR_W]);
        sel_req.wdata = DATA_W_DEF'(req_wdata[i*DATA_W +: DATA_W]);
      end
    end
  end

  assign sel_in_range = addr_in_range(sel_req.addr, MEM_DEPTH);
  assign resp_onehot  = NREQ'(1) << id_q;

  // The memory strobes are registered, so they are loaded on the accept edge
  // and are therefore live during the ISSUE cycle. Address and data copies
  // captured here are the only ones the memory ever sees.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    id_d         = id_q;
    we_d         = we_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    resp_valid_d = '0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|grant) begin
          id_d   = grant_idx;
          last_d = grant_idx;
          we_d   = sel_req.we;
          err_d  = !sel_in_range;
          if (sel_in_range) begin
            mem_en_d    = 1'b1;
            mem_we_d    = sel_req.we;
            mem_addr_d  = ADDR_W'(sel_req.addr);
            mem_wdata_d = DATA_W'(sel_req.wdata);
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (err_q || we_q) begin
          resp_valid_d = resp_onehot;
          resp_err_d   = err_q;
          state_d      = S_RESP;
        end else begin
          cnt_d   = 3'(RD_LAT);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Count 1 marks the cycle in which mem_rdata is valid.
        if (cnt_q == 3'd1) begin
          resp_valid_d = resp_onehot;
          resp_rdata_d = mem_rdata;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_q       <= IDX_W'(NREQ - 1);
      id_q         <= '0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      id_q         <= id_d;
      we_q         <= we_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign mem_en         = mem_en_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign resp_valid     = resp_valid_q;
  assign resp_rdata     = resp_rdata_q;
  assign resp_err       = resp_err_q;
  assign dbg_state      = state_q;
  assign dbg_last_grant = last_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: random requests from two requesters, a
// behavioural memory macro, a reference model that predicts grants,
// memory accesses and responses, and queue-based monitors.
module tb_mem_req_arbiter;
  import mem_ctrl_pkg::*;

  localparam int NREQ   = 2;
  localparam int AW     = 16;
  localparam int DW     = 32;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 64;
  localparam int IW     = $clog2(NREQ);
  localparam int RW     = 32 + 8 + 1 + DW;   // {cycle, id, err, rdata}
  localparam int MW     = 32 + 1 + AW + DW;  // {cycle, we, addr, wdata}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [NREQ-1:0]    req_valid, req_ready, req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    resp_valid;
  logic [DW-1:0]      resp_rdata;
  logic               resp_err;
  logic               mem_en, mem_we;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata, mem_rdata;
  logic [1:0]         dbg_state;
  logic [IW-1:0]      dbg_last_grant;

  mem_req_arbiter #(
    .NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .MEM_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state), .dbg_last_grant(dbg_last_grant)
  );

  // ---------------- memory macro ----------------
  logic [DW-1:0] init_val [DEPTH];
  logic          load_mem = 1'b1;
  logic [DW-1:0] mem_arr  [DEPTH];
  logic [DW-1:0] rd_pipe  [RD_LAT];

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < DEPTH; i++) mem_arr[i] <= init_val[i];
    end else if (mem_en === 1'b1 && mem_we === 1'b1) begin
      mem_arr[mem_addr[5:0]] <= mem_wdata;
    end
    rd_pipe[0] <= (mem_en === 1'b1 && mem_we === 1'b0) ? mem_arr[mem_addr[5:0]] : 32'hDEAD_BEEF;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_q[$];
  logic [MW-1:0] mem_exp_q[$];

  logic [DW-1:0]   ref_mem [DEPTH];
  int              m_last;
  int              m_busy;
  logic [NREQ-1:0] pend;
  logic            p_we    [NREQ];
  logic [AW-1:0]   p_addr  [NREQ];
  logic [DW-1:0]   p_wdata [NREQ];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(9) == 0) return AW'($urandom_range(65535, DEPTH));
    return AW'($urandom_range(15));
  endfunction

  // ---------------- driver + reference model ----------------
  // One clock cycle: refresh requester inputs, predict the grant from the
  // round-robin rule and the busy time of the previous access, then book the
  // expected memory access and response for the predicted winner.
  task automatic cycle_step(input int prob);
    logic [NREQ-1:0] exp_ready;
    int win;
    int c;
    @(negedge clk);
    for (int k = 0; k < NREQ; k++) begin
      if (!pend[k] && prob > 0 && $urandom_range(99) < prob) begin
        pend[k]    = 1'b1;
        p_we[k]    = 1'($urandom_range(1));
        p_addr[k]  = rand_addr();
        p_wdata[k] = $urandom();
      end
      req_valid[k]          = pend[k];
      req_we[k]             = pend[k] ? p_we[k] : 1'($urandom_range(1));
      req_addr[k*AW +: AW]  = pend[k] ? p_addr[k] : AW'($urandom());
      req_wdata[k*DW +: DW] = pend[k] ? p_wdata[k] : $urandom();
    end
    exp_ready = '0;
    win = -1;
    if (m_busy > 0) begin
      m_busy--;
    end else begin
      for (int i = 1; i <= NREQ; i++) begin
        c = (m_last + i) % NREQ;
        if (win < 0 && pend[c]) win = c;
      end
    end
    if (win >= 0) exp_ready[win] = 1'b1;
    #1;
    chk("req_ready", 128'(req_ready), 128'(exp_ready));
    if (win >= 0) begin
      pend[win] = 1'b0;
      m_last    = win;
      if (p_addr[win] >= AW'(DEPTH)) begin
        exp_q.push_back({32'(cyc + 2), 8'(win), 1'b1, 32'h0});
        m_busy = 2;
      end else begin
        mem_exp_q.push_back({32'(cyc + 1), p_we[win], p_addr[win], p_wdata[win]});
        if (p_we[win]) begin
          ref_mem[p_addr[win][5:0]] = p_wdata[win];
          exp_q.push_back({32'(cyc + 2), 8'(win), 1'b0, 32'h0});
          m_busy = 2;
        end else begin
          exp_q.push_back({32'(cyc + 2 + RD_LAT), 8'(win), 1'b0, ref_mem[p_addr[win][5:0]]});
          m_busy = 2 + RD_LAT;
        end
      end
    end
  endtask

  task automatic directed(input int k, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[k]    = 1'b1;
    p_we[k]    = we;
    p_addr[k]  = a;
    p_wdata[k] = d;
    for (int n = 0; n < 20 && pend[k]; n++) cycle_step(0);
    chk("directed_accept", 128'(pend[k]), 128'(0));
  endtask

  task automatic drain(input int n);
    repeat (n) cycle_step(0);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    logic [RW-1:0] e;
    logic [MW-1:0] me;
    int id;
    if (resp_valid !== '0) begin
      chk("resp_onehot", 128'($onehot(resp_valid)), 128'(1));
      id = 0;
      for (int i = NREQ - 1; i >= 0; i--) if (resp_valid[i] === 1'b1) id = i;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected actual=%0h required=none (t=%0t)", resp_valid, $time);
      end else begin
        e = exp_q.pop_front();
        chk("resp_cycle", 128'(cyc), 128'(e[RW-1 -: 32]));
        chk("resp_id", 128'(id), 128'(e[DW+1 +: 8]));
        chk("resp_err", 128'(resp_err), 128'(e[DW]));
        chk("resp_rdata", 128'(resp_rdata), 128'(e[DW-1:0]));
      end
    end else if (exp_q.size() > 0 && int'(exp_q[0][RW-1 -: 32]) <= cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL resp_missing actual=none required=id%0d@%0d (t=%0t)", e[DW+1 +: 8], e[RW-1 -: 32], $time);
    end

    if (mem_en === 1'b1) begin
      if (mem_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mem_unexpected actual=addr%0h required=none (t=%0t)", mem_addr, $time);
      end else begin
        me = mem_exp_q.pop_front();
        chk("mem_cycle", 128'(cyc), 128'(me[MW-1 -: 32]));
        chk("mem_we", 128'(mem_we), 128'(me[AW+DW]));
        chk("mem_addr", 128'(mem_addr), 128'(me[AW+DW-1 -: AW]));
        chk("mem_wdata", 128'(mem_wdata), 128'(me[DW-1:0]));
      end
    end else begin
      chk("mem_idle_zero", 128'({mem_en, mem_we, mem_addr, mem_wdata}), 128'(0));
      if (mem_exp_q.size() > 0 && int'(mem_exp_q[0][MW-1 -: 32]) <= cyc) begin
        me = mem_exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL mem_missing actual=none required=addr%0h@%0d (t=%0t)", me[AW+DW-1 -: AW], me[MW-1 -: 32], $time);
      end
    end
  end

  // ---------------- main sequence ----------------
  logic [1:0] idle_code;

  initial begin
    idle_code = S_IDLE;
    for (int i = 0; i < DEPTH; i++) begin
      init_val[i] = $urandom();
      ref_mem[i]  = init_val[i];
    end
    pend   = '0;
    m_last = NREQ - 1;
    m_busy = 0;
    for (int k = 0; k < NREQ; k++) begin
      p_we[k] = 1'b0; p_addr[k] = '0; p_wdata[k] = '0;
    end
    rst       = 1'b1;
    req_valid = '1;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;

    // Reset holds everything quiet even with both requesters valid.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", 128'(req_ready), 128'(0));
    chk("rst_resp_valid", 128'(resp_valid), 128'(0));
    chk("rst_resp_rdata", 128'(resp_rdata), 128'(0));
    chk("rst_resp_err", 128'(resp_err), 128'(0));
    chk("rst_mem_en", 128'(mem_en), 128'(0));
    chk("rst_mem_we", 128'(mem_we), 128'(0));
    chk("rst_mem_addr", 128'(mem_addr), 128'(0));
    chk("rst_mem_wdata", 128'(mem_wdata), 128'(0));
    chk("rst_state", 128'(dbg_state), 128'(idle_code));
    chk("rst_last_grant", 128'(dbg_last_grant), 128'(NREQ - 1));
    rst       = 1'b0;
    load_mem  = 1'b0;
    req_valid = '0;

    // First cycle out of reset with both valid: requester 0 first.
    pend = '1;
    for (int k = 0; k < NREQ; k++) begin
      p_we[k] = 1'b1; p_addr[k] = AW'(10 + k); p_wdata[k] = 32'h1000 + k;
    end
    drain(20);

    repeat (300) cycle_step(40);
    repeat (80) cycle_step(100);
    drain(25);

    // Write then read back.
    directed(0, 1'b1, 16'h0003, 32'h0000_00A5);
    drain(8);
    directed(0, 1'b0, 16'h0003, 32'h0);
    drain(8);
    // First out-of-range word.
    directed(1, 1'b0, 16'h0040, 32'h0);
    drain(8);

    // Reset during WAIT of a read.
    directed(0, 1'b0, 16'h0005, 32'h0);
    cycle_step(0);
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '1;
    pend      = '0;
    exp_q.delete();
    m_busy    = 0;
    m_last    = NREQ - 1;
    #1;
    chk("rst_mid_req_ready", 128'(req_ready), 128'(0));
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '0;
    #1;
    chk("rst_mid_state", 128'(dbg_state), 128'(idle_code));
    chk("rst_mid_last_grant", 128'(dbg_last_grant), 128'(NREQ - 1));
    drain(8);

    repeat (300) cycle_step(70);
    drain(25);

    chk("resp_queue_empty", 128'(exp_q.size()), 128'(0));
    chk("mem_queue_empty", 128'(mem_exp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
